instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- IF stage of the RV32IM pipeline, directly upstream of the instruction memory.
- Owns the PC and issues READ/ADDRESS requests to instruction_memory.
- Honours the memory's BUSYWAIT handshake and drives the IF/ID pipeline register: instruction, PC, PC+4, valid.
- Accepts stall from the hazard unit and branch/jump redirects from EX.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- MIN_REQ_CYCLES, 1, number of rising edges READ must be held before a low BUSYWAIT counts as completion (1..3).

Ports:
- CLK  in  1  pipeline clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- STALL  in  1  hazard unit: hold IF/ID outputs.
- BRANCH_TAKEN  in  1  EX redirect request (single-cycle pulse).
- BRANCH_TARGET  in  32  redirect byte address.
- IMEM_READ  out  1  read request to instruction memory.
- IMEM_ADDRESS  out  32  byte address of the fetch (= PC).
- IMEM_READINST  in  32  instruction word from memory.
- IMEM_BUSYWAIT  in  1  memory busy; rises combinationally on READ.
- IF_INSTR  out  32  IF/ID instruction.
- IF_PC  out  32  IF/ID PC of IF_INSTR.
- IF_PC4  out  32  IF_PC + 4.
- IF_VALID  out  1  IF/ID entry holds a real instruction.

Behaviour:
- Reset (async, RESET_N=0):
  - PC=RESET_VECTOR, state=IDLE, IMEM_READ=0.
  - IF_INSTR=32'h0000_0013 (NOP), IF_PC=0, IF_PC4=0, IF_VALID=0.
  - Buffer cleared, squash flag cleared, request-age counter cleared.
  - Reset asserted mid-request drops IMEM_READ immediately and abandons the fetch; memory state is not otherwise touched.
- FSM states: IDLE, REQ, HOLD. IMEM_READ=1 only in REQ. IMEM_ADDRESS=PC at all times.
- IDLE: next edge -> REQ. Guarantees a READ low->high edge per fetch, since memory BUSYWAIT is edge-sensitive on READ.
- REQ completion: completion = rising edge where the age counter >= MIN_REQ_CYCLES and IMEM_BUSYWAIT==0. Age counter increments each REQ edge and saturates.
- On completion:
  - Not squashed, STALL=0: IF_INSTR<=IMEM_READINST, IF_PC<=PC, IF_PC4<=PC+4, IF_VALID<=1, PC<=PC+4, -> IDLE.
  - Not squashed, STALL=1: buffer<=IMEM_READINST, buffer PC<=PC, PC<=PC+4, -> HOLD. IF/ID outputs unchanged.
  - Squashed: result discarded, PC<=held redirect target, squash cleared, -> IDLE.
- HOLD (IMEM_READ=0): when STALL=0, IF/ID <= buffer (IF_VALID=1), -> IDLE. Otherwise stay.
- BRANCH_TAKEN (priority over STALL and completion), target = {BRANCH_TARGET[31:2],2'b00}:
  - IF_VALID<=0 on the same edge (flush), even if STALL=1.
  - In IDLE or HOLD: PC<=target, buffer dropped, -> IDLE.
  - In REQ, not completing: squash<=1, redirect register<=target, stay in REQ. A second redirect overwrites the target.
  - In REQ and completing on the same edge: result discarded, PC<=target, -> IDLE.
- STALL without completion or redirect: IF/ID outputs and PC hold; an in-flight REQ continues.
- Arithmetic: PC+4 is 32-bit modulo, so 32'hFFFF_FFFC wraps to 0. No misalignment trap.
- Throughput: at most one instruction per 3 cycles (IDLE, REQ, completion edge), plus memory latency.

Decomposition:
- Shared package rv32_pipeline_pkg holds:
  - fetch state encoding (IDLE=2'd0, REQ=2'd1, HOLD=2'd2);
  - NOP constant 32'h0000_0013;
  - PC width constant 32.
- No sub-module; the PC register, FSM and one-entry buffer stay in one module.

Test Plan:
- Reset then free-run against a 40-time-unit memory holding addi words at 0,4,8 -> IF_VALID pulses with IF_PC=0,4,8 in order, IF_PC4=IF_PC+4, IF_INSTR matches memory, IMEM_READ drops between fetches.
- STALL=1 across a completion at PC=4 -> IF/ID holds PC=0 entry; after STALL=0, the next edge shows IF_PC=4 from the buffer and no refetch of address 4.
- BRANCH_TAKEN, target 32'h40, mid-REQ at PC=8 -> IF_VALID=0 that edge, fetched word for 8 never appears, next request at IMEM_ADDRESS=32'h40.
- BRANCH_TAKEN on the same edge as completion, with STALL=1 and target 32'h13 -> flush wins, PC=32'h10, buffer empty.
- RESET_N low while IMEM_READ=1 -> IMEM_READ=0 and IF_VALID=0 without a clock edge; after release the first request is at RESET_VECTOR.
- PC preset near 32'hFFFF_FFFC via branch -> after the fetch completes, the next IMEM_ADDRESS=0.

Source files
------------

// File: rtl/rv32_pipeline_pkg.sv
// Shared definitions for the RV32IM pipeline stages.
package rv32_pipeline_pkg;

  localparam int unsigned PC_W = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_e;

  // Redirect targets are forced onto a word boundary; there is no misalignment trap.
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, runs the READ/BUSYWAIT handshake with instruction memory
// and fills the IF/ID register, with a one-entry buffer for stalls and a squash for redirects.
module instruction_fetch_unit
  import rv32_pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter int unsigned MIN_REQ_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDRESS,
  input  logic [31:0] IMEM_READINST,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] IF_INSTR,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_PC4,
  output logic        IF_VALID
);

  localparam logic [1:0] MIN_AGE = 2'(MIN_REQ_CYCLES);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         read_q, read_d;
  logic [1:0]   age_q, age_d;
  logic         squash_q, squash_d;
  logic [31:0]  redir_q, redir_d;
  logic [31:0]  buf_instr_q, buf_instr_d;
  logic [31:0]  buf_pc_q, buf_pc_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic [31:0]  if_pc4_q, if_pc4_d;
  logic         if_valid_q, if_valid_d;

  logic         completing_s;
  logic [1:0]   age_inc_s;
  logic [31:0]  target_s;
  logic [31:0]  pc_plus4_s;

  assign completing_s = (state_q == FETCH_REQ) && (age_q >= MIN_AGE) && !IMEM_BUSYWAIT;
  assign age_inc_s    = (age_q == 2'd3) ? 2'd3 : age_q + 2'd1;
  assign target_s     = word_align(BRANCH_TARGET);
  assign pc_plus4_s   = pc_q + 32'd4;

  // Next-state logic; a redirect outranks both completion and stall.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    age_d       = age_q;
    squash_d    = squash_q;
    redir_d     = redir_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    if_instr_d  = if_instr_q;
    if_pc_d     = if_pc_q;
    if_pc4_d    = if_pc4_q;
    if_valid_d  = if_valid_q;

    case (state_q)
      FETCH_IDLE: begin
        if (BRANCH_TAKEN) begin
          pc_d       = target_s;
          if_valid_d = 1'b0;
          squash_d   = 1'b0;
        end else begin
          state_d = FETCH_REQ;
          age_d   = 2'd0;
        end
      end
      FETCH_REQ: begin
        if (BRANCH_TAKEN) begin
          if_valid_d = 1'b0;
          if (completing_s) begin
            pc_d     = target_s;
            squash_d = 1'b0;
            state_d  = FETCH_IDLE;
          end else begin
            squash_d = 1'b1;
            redir_d  = target_s;
            age_d    = age_inc_s;
          end
        end else if (completing_s) begin
          state_d = FETCH_IDLE;
          if (squash_q) begin
            pc_d     = redir_q;
            squash_d = 1'b0;
          end else if (STALL) begin
            buf_instr_d = IMEM_READINST;
            buf_pc_d    = pc_q;
            pc_d        = pc_plus4_s;
            state_d     = FETCH_HOLD;
          end else begin
            if_instr_d = IMEM_READINST;
            if_pc_d    = pc_q;
            if_pc4_d   = pc_plus4_s;
            if_valid_d = 1'b1;
            pc_d       = pc_plus4_s;
          end
        end else begin
          age_d = age_inc_s;
        end
      end
      FETCH_HOLD: begin
        if (BRANCH_TAKEN) begin
          pc_d        = target_s;
          if_valid_d  = 1'b0;
          squash_d    = 1'b0;
          buf_instr_d = NOP_INSTR;
          buf_pc_d    = 32'h0000_0000;
          state_d     = FETCH_IDLE;
        end else if (!STALL) begin
          if_instr_d = buf_instr_q;
          if_pc_d    = buf_pc_q;
          if_pc4_d   = buf_pc_q + 32'd4;
          if_valid_d = 1'b1;
          state_d    = FETCH_IDLE;
        end else begin
          state_d = FETCH_HOLD;
        end
      end
      default: begin
        state_d = FETCH_IDLE;
      end
    endcase

    read_d = (state_d == FETCH_REQ);
  end

  // State and IF/ID registers; reset drops READ without waiting for a clock.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= FETCH_IDLE;
      pc_q        <= RESET_VECTOR;
      read_q      <= 1'b0;
      age_q       <= 2'd0;
      squash_q    <= 1'b0;
      redir_q     <= 32'h0000_0000;
      buf_instr_q <= NOP_INSTR;
      buf_pc_q    <= 32'h0000_0000;
      if_instr_q  <= NOP_INSTR;
      if_pc_q     <= 32'h0000_0000;
      if_pc4_q    <= 32'h0000_0000;
      if_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      read_q      <= read_d;
      age_q       <= age_d;
      squash_q    <= squash_d;
      redir_q     <= redir_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      if_instr_q  <= if_instr_d;
      if_pc_q     <= if_pc_d;
      if_pc4_q    <= if_pc4_d;
      if_valid_q  <= if_valid_d;
    end
  end

  assign IMEM_READ    = read_q;
  assign IMEM_ADDRESS = pc_q;
  assign IF_INSTR     = if_instr_q;
  assign IF_PC        = if_pc_q;
  assign IF_PC4       = if_pc4_q;
  assign IF_VALID     = if_valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: latency memory model, program-order reference model,
// directed scenarios followed by randomized stall/redirect traffic.
module tb_instruction_fetch_unit;
  import rv32_pipeline_pkg::*;

  localparam logic [31:0] RV      = 32'h0000_0000;
  localparam int          MEM_LAT = 40;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        STALL = 1'b0;
  logic        BRANCH_TAKEN = 1'b0;
  logic [31:0] BRANCH_TARGET = 32'h0;
  logic        IMEM_READ;
  logic [31:0] IMEM_ADDRESS;
  logic [31:0] IMEM_READINST = 32'hDEAD_BEEF;
  logic        IMEM_BUSYWAIT = 1'b0;
  logic [31:0] IF_INSTR, IF_PC, IF_PC4;
  logic        IF_VALID;

  int tests = 0;
  int fails = 0;

  instruction_fetch_unit #(.RESET_VECTOR(RV), .MIN_REQ_CYCLES(1)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .STALL(STALL), .BRANCH_TAKEN(BRANCH_TAKEN),
    .BRANCH_TARGET(BRANCH_TARGET), .IMEM_READ(IMEM_READ), .IMEM_ADDRESS(IMEM_ADDRESS),
    .IMEM_READINST(IMEM_READINST), .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .IF_INSTR(IF_INSTR),
    .IF_PC(IF_PC), .IF_PC4(IF_PC4), .IF_VALID(IF_VALID)
  );

  always #5 CLK = ~CLK;

  // Memory contents: an addi word derived from the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [11:0] imm;
    imm = a[13:2] ^ a[31:20] ^ 12'h5A5;
    return {imm, 5'd0, 3'b000, 5'd1, 7'b0010011};
  endfunction

  // Memory: BUSYWAIT rises with READ and clears about MEM_LAT later; ticks never land on clock edges.
  logic   tick = 1'b0;
  logic   read_prev = 1'b0;
  longint t_rise = 0;
  initial begin
    #8;
    forever begin
      tick = ~tick;
      #10;
    end
  end
  always @(IMEM_READ or tick) begin
    if (IMEM_READ && !read_prev) t_rise = longint'($time);
    read_prev     = IMEM_READ;
    IMEM_BUSYWAIT = IMEM_READ && ((longint'($time) - t_rise) < longint'(MEM_LAT));
    IMEM_READINST = (IMEM_READ && !IMEM_BUSYWAIT) ? mem_word(IMEM_ADDRESS) : 32'hDEAD_BEEF;
  end

  logic [31:0] req_q[$];
  always @(posedge IMEM_READ) req_q.push_back(IMEM_ADDRESS);

  // Reference model: expected next PC in program order plus the IF/ID contents it implies.
  logic [31:0] exp_pc, m_pc, m_instr, m_pc4;
  logic        m_valid;
  int          deliveries = 0;
  int          idle_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_pc   = RV;
    m_valid  = 1'b0;
    m_pc     = 32'h0;
    m_pc4    = 32'h0;
    m_instr  = NOP_INSTR;
    idle_cnt = 0;
  endtask

  task automatic step();
    logic        br, st;
    logic [31:0] tgt;
    br  = BRANCH_TAKEN;
    st  = STALL;
    tgt = BRANCH_TARGET & 32'hFFFF_FFFC;
    @(posedge CLK);
    #1;
    if (br) begin
      m_valid  = 1'b0;
      exp_pc   = tgt;
      idle_cnt = 0;
    end else if (!st && IF_VALID === 1'b1 && (!m_valid || IF_PC !== m_pc)) begin
      chk("deliv_pc", IF_PC, exp_pc);
      chk("deliv_instr", IF_INSTR, mem_word(exp_pc));
      chk("deliv_pc4", IF_PC4, exp_pc + 32'd4);
      chk("read_low_after_fetch", {31'd0, IMEM_READ}, 32'd0);
      m_valid  = 1'b1;
      m_pc     = exp_pc;
      m_instr  = mem_word(exp_pc);
      m_pc4    = exp_pc + 32'd4;
      exp_pc   = exp_pc + 32'd4;
      deliveries++;
      idle_cnt = 0;
    end else if (!st) begin
      idle_cnt++;
    end
    chk("ifid_valid", {31'd0, IF_VALID}, {31'd0, m_valid});
    chk("ifid_pc", IF_PC, m_pc);
    chk("ifid_instr", IF_INSTR, m_instr);
    chk("ifid_pc4", IF_PC4, m_pc4);
    tests++;
    assert (idle_cnt <= 20) else begin
      fails++;
      $error("FAIL liveness: observed %0d unstalled cycles without a fetch, expected <= 20", idle_cnt);
    end
  endtask

  task automatic wait_delivery(input string tag);
    int start;
    int n;
    start = deliveries;
    n = 0;
    while (deliveries == start && n < 40) begin
      step();
      n++;
    end
    chk(tag, 32'(deliveries - start), 32'd1);
  endtask

  initial begin
    int cnt4;
    logic found;
    model_reset();

    // Reset state
    @(posedge CLK);
    #1;
    chk("rst_read", {31'd0, IMEM_READ}, 32'd0);
    chk("rst_addr", IMEM_ADDRESS, RV);
    chk("rst_instr", IF_INSTR, NOP_INSTR);
    chk("rst_pc", IF_PC, 32'h0);
    chk("rst_pc4", IF_PC4, 32'h0);
    chk("rst_valid", {31'd0, IF_VALID}, 32'd0);
    RESET_N = 1'b1;

    // Free-run: 0, 4, 8 in order
    wait_delivery("A_d0");
    chk("A_pc0", IF_PC, 32'h0);
    wait_delivery("A_d1");
    chk("A_pc1", IF_PC, 32'h4);
    wait_delivery("A_d2");
    chk("A_pc2", IF_PC, 32'h8);

    // Stall across the completion at PC=4
    BRANCH_TARGET = 32'h0;
    BRANCH_TAKEN  = 1'b1;
    step();
    BRANCH_TAKEN  = 1'b0;
    req_q.delete();
    wait_delivery("B_d0");
    STALL = 1'b1;
    repeat (12) step();
    chk("B_hold_read", {31'd0, IMEM_READ}, 32'd0);
    chk("B_hold_addr", IMEM_ADDRESS, 32'h8);
    chk("B_hold_pc", IF_PC, 32'h0);
    STALL = 1'b0;
    step();
    chk("B_buf_pc", IF_PC, 32'h4);
    chk("B_buf_valid", {31'd0, IF_VALID}, 32'd1);

    // Redirect mid-request at PC=8
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      found = IMEM_READ && (IMEM_ADDRESS == 32'h8);
    end
    chk("C_req8_seen", {31'd0, found}, 32'd1);
    cnt4 = 0;
    foreach (req_q[k]) if (req_q[k] == 32'h4) cnt4++;
    chk("B_no_refetch", 32'(cnt4), 32'd1);
    step();
    BRANCH_TARGET = 32'h40;
    BRANCH_TAKEN  = 1'b1;
    step();
    BRANCH_TAKEN  = 1'b0;
    chk("C_flush_valid", {31'd0, IF_VALID}, 32'd0);
    req_q.delete();
    wait_delivery("C_d40");
    chk("C_pc40", IF_PC, 32'h40);
    chk("C_req_count", 32'(req_q.size()), 32'd1);
    chk("C_first_req", (req_q.size() > 0) ? req_q[0] : 32'hFFFF_FFFF, 32'h40);

    // Redirect on the completion edge while stalled
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      #4;
      found = IMEM_READ && !IMEM_BUSYWAIT;
    end
    chk("D_completion_seen", {31'd0, found}, 32'd1);
    STALL         = 1'b1;
    BRANCH_TARGET = 32'h13;
    BRANCH_TAKEN  = 1'b1;
    step();
    BRANCH_TAKEN  = 1'b0;
    STALL         = 1'b0;
    chk("D_pc", IMEM_ADDRESS, 32'h10);
    chk("D_read", {31'd0, IMEM_READ}, 32'd0);
    chk("D_valid", {31'd0, IF_VALID}, 32'd0);
    step();
    chk("D_buf_empty", {31'd0, IF_VALID}, 32'd0);
    chk("D_req_read", {31'd0, IMEM_READ}, 32'd1);
    chk("D_req_addr", IMEM_ADDRESS, 32'h10);
    wait_delivery("D_d10");
    chk("D_pc10", IF_PC, 32'h10);

    // Asynchronous reset mid-request
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      found = IMEM_READ;
    end
    chk("E_req_seen", {31'd0, found}, 32'd1);
    chk("E_valid_before", {31'd0, IF_VALID}, 32'd1);
    RESET_N = 1'b0;
    #1;
    chk("E_read_async", {31'd0, IMEM_READ}, 32'd0);
    chk("E_valid_async", {31'd0, IF_VALID}, 32'd0);
    chk("E_addr_async", IMEM_ADDRESS, RV);
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    model_reset();
    req_q.delete();
    wait_delivery("E_d0");
    chk("E_first_req", (req_q.size() > 0) ? req_q[0] : 32'hFFFF_FFFF, RV);

    // PC wrap at the top of the address space
    BRANCH_TARGET = 32'hFFFF_FFFE;
    BRANCH_TAKEN  = 1'b1;
    step();
    BRANCH_TAKEN  = 1'b0;
    wait_delivery("F_dtop");
    chk("F_pc_top", IF_PC, 32'hFFFF_FFFC);
    chk("F_pc4_wrap", IF_PC4, 32'h0);
    chk("F_next_addr", IMEM_ADDRESS, 32'h0);
    wait_delivery("F_d0");
    chk("F_pc0", IF_PC, 32'h0);

    // Randomized stall / redirect traffic
    for (int i = 0; i < 400; i++) begin
      STALL        = ($urandom_range(0, 3) == 0);
      BRANCH_TAKEN = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) BRANCH_TARGET = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
      else BRANCH_TARGET = 32'($urandom_range(0, 1023));
      step();
    end
    STALL        = 1'b0;
    BRANCH_TAKEN = 1'b0;
    wait_delivery("G_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
